// File: rtl/uart_rx_oversampled_if.sv
// Serial receive bundle: line input, per-frame configuration and the decoded byte with status.
// Latency: none (wiring only).
// Backpressure: none; the receiver presents each byte as a one-cycle strobe with no ready.
interface uart_rx_oversampled_if;
    logic       rx;
    logic [1:0] baud_select;
    logic       parity_sel;
    logic [7:0] data;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    // Line/config driver and byte consumer
    modport master (
        output rx, baud_select, parity_sel,
        input  data, data_valid, parity_err, frame_err, busy
    );

    // Receiver side
    modport slave (
        input  rx, baud_select, parity_sel,
        output data, data_valid, parity_err, frame_err, busy
    );
endinterface

// File: rtl/uart_rx_oversampled.sv
// 16x-oversampled UART receiver (8 data bits, parity, 1 stop); optional 2-of-3 vote via RX_MAJORITY_VOTE_EN.
// Latency: data_valid one clk after the stop-bit decision tick (tick 8 of the stop bit).
// Backpressure: none; data_valid is a one-cycle strobe and the consumer must take it.
module uart_rx_oversampled #(
    parameter int CLK_FREQ   = 50000000,
    parameter int OVERSAMPLE = 16        // tick counter below is 4 bits wide; keep at 16
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_rx_oversampled_if.slave  bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    // Clocks per sample tick, rounded to nearest: (CLK + 8*baud) / (16*baud)
    localparam int HALF = OVERSAMPLE / 2;
    localparam int DIV0 = (CLK_FREQ + HALF * 9600)  / (OVERSAMPLE * 9600);
    localparam int DIV1 = (CLK_FREQ + HALF * 19200) / (OVERSAMPLE * 19200);
    localparam int DIV2 = (CLK_FREQ + HALF * 38400) / (OVERSAMPLE * 38400);
    localparam int DIV3 = (CLK_FREQ + HALF * 57600) / (OVERSAMPLE * 57600);
    localparam int DW   = $clog2(DIV0 + 1);

    localparam logic [DW-1:0] DMAX0 = DW'(DIV0 - 1);
    localparam logic [DW-1:0] DMAX1 = DW'(DIV1 - 1);
    localparam logic [DW-1:0] DMAX2 = DW'(DIV2 - 1);
    localparam logic [DW-1:0] DMAX3 = DW'(DIV3 - 1);

    logic          rx_meta_q, rx_meta_d;
    logic          rx_sync_q, rx_sync_d;
    logic          rx_prev_q, rx_prev_d;
    logic [2:0]    state_q, state_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [3:0]    tick_cnt_q, tick_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [1:0]    baud_q, baud_d;
    logic          psel_q, psel_d;
    logic          par_bit_q, par_bit_d;
    logic          samp7_q, samp7_d;
`ifdef RX_MAJORITY_VOTE_EN
    logic          samp6_q, samp6_d;
`endif
    logic [7:0]    data_q, data_d;
    logic          data_valid_q, data_valid_d;
    logic          parity_err_q, parity_err_d;
    logic          frame_err_q, frame_err_d;

    logic [DW-1:0] div_max;
    logic          tick;
    logic          fall;
    logic          decide;
    logic          bit_val;

    // Divider terminal count for the baud rate latched at frame start
    always_comb begin
        div_max = DMAX0;
        case (baud_q)
            2'd0:    div_max = DMAX0;
            2'd1:    div_max = DMAX1;
            2'd2:    div_max = DMAX2;
            default: div_max = DMAX3;
        endcase
    end

    assign tick   = (div_cnt_q == div_max);
    assign fall   = rx_prev_q & ~rx_sync_q;
    // Bit value is resolved on tick 8 so both builds share identical frame timing
    assign decide = tick && (tick_cnt_q == 4'd8);

`ifdef RX_MAJORITY_VOTE_EN
    assign bit_val = (samp6_q & samp7_q) | (samp6_q & rx_sync_q) | (samp7_q & rx_sync_q);
`else
    assign bit_val = samp7_q;
`endif

    // Next-state logic: synchronizer, tick generation, sampling and the frame FSM
    always_comb begin
        rx_meta_d    = bus.rx;
        rx_sync_d    = rx_meta_q;
        rx_prev_d    = rx_sync_q;
        state_d      = state_q;
        div_cnt_d    = tick ? '0 : div_cnt_q + DW'(1);
        tick_cnt_d   = tick ? tick_cnt_q + 4'd1 : tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        baud_d       = baud_q;
        psel_d       = psel_q;
        par_bit_d    = par_bit_q;
        samp7_d      = (tick && tick_cnt_q == 4'd7) ? rx_sync_q : samp7_q;
`ifdef RX_MAJORITY_VOTE_EN
        samp6_d      = (tick && tick_cnt_q == 4'd6) ? rx_sync_q : samp6_q;
`endif
        data_d       = data_q;
        data_valid_d = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    // Realign bit timing to the start edge and freeze configuration
                    state_d    = S_START;
                    div_cnt_d  = '0;
                    tick_cnt_d = '0;
                    baud_d     = bus.baud_select;
                    psel_d     = bus.parity_sel;
                end
            end
            S_START: begin
                if (decide) begin
                    if (bit_val) begin
                        state_d = S_IDLE;            // glitch, not a start bit
                    end else begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end
                end
            end
            S_DATA: begin
                if (decide) begin
                    shift_d   = {bit_val, shift_q[7:1]};  // LSB arrives first
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (decide) begin
                    par_bit_d = bit_val;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (decide) begin
                    data_d       = shift_q;
                    parity_err_d = par_bit_q ^ (^shift_q) ^ psel_q;
                    frame_err_d  = ~bit_val;
                    data_valid_d = 1'b1;
                    state_d      = bit_val ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                if (rx_sync_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Register update; synchronizer resets to the idle-high line level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            state_q      <= S_IDLE;
            div_cnt_q    <= '0;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            baud_q       <= '0;
            psel_q       <= 1'b0;
            par_bit_q    <= 1'b0;
            samp7_q      <= 1'b1;
`ifdef RX_MAJORITY_VOTE_EN
            samp6_q      <= 1'b1;
`endif
            data_q       <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_meta_q    <= rx_meta_d;
            rx_sync_q    <= rx_sync_d;
            rx_prev_q    <= rx_prev_d;
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            baud_q       <= baud_d;
            psel_q       <= psel_d;
            par_bit_q    <= par_bit_d;
            samp7_q      <= samp7_d;
`ifdef RX_MAJORITY_VOTE_EN
            samp6_q      <= samp6_d;
`endif
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign bus.data       = data_q;
    assign bus.data_valid = data_valid_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled: frame vectors, break, glitch, reset abort, back-to-back.
// Clock scaled to 1.8432 MHz so dividers are exact (12/6/3/2) and frames stay short.
// Expected bytes are queued when a frame is driven and popped on each data_valid.
module tb_uart_rx_oversampled;
    localparam int CLK_FREQ = 1843200;

    typedef struct {
        logic [1:0] baud;
        logic       psel;
        logic [7:0] b;
        logic       pbit;
        logic       stop;
        logic       chg;
        logic [7:0] edata;
        logic       eperr;
        logic       eferr;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_rx_oversampled_if bus();

    uart_rx_oversampled #(.CLK_FREQ(CLK_FREQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t sb[$];
    int   valid_cyc[$];
    exp_t m_exp;
    vec_t vec[10];
    logic [10:0] f;
    int   len;

    function automatic int bit_len(input logic [1:0] sel);
        case (sel)
            2'd0:    return CLK_FREQ / 9600;
            2'd1:    return CLK_FREQ / 19200;
            2'd2:    return CLK_FREQ / 38400;
            default: return CLK_FREQ / 57600;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic p, input logic fe);
        exp_t e;
        e.data = d;
        e.perr = p;
        e.ferr = fe;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k;
        k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL %s: %0d expected frames not received within %0d cycles, required 0", name, sb.size(), budget);
            sb.delete();
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic pbit, input logic stop,
                              input int blen, input logic chg);
        logic [10:0] fr;
        fr = {stop, pbit, b, 1'b0};
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            bus.rx = fr[k];
            if (chg && k == 1) begin
                bus.baud_select = ~bus.baud_select;
                bus.parity_sel  = ~bus.parity_sel;
            end
            repeat (blen - 1) @(negedge clk);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: every strobe must match the oldest queued frame
    always @(negedge clk) begin
        if (bus.data_valid === 1'b1) begin
            valid_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid: data_valid with data %0h, required no strobe", bus.data);
            end else begin
                m_exp = sb.pop_front();
                check("data",       32'(bus.data),       32'(m_exp.data));
                check("parity_err", 32'(bus.parity_err), 32'(m_exp.perr));
                check("frame_err",  32'(bus.frame_err),  32'(m_exp.ferr));
            end
        end
    end

    initial begin : watchdog
        repeat (90000) @(posedge clk);
        n_err++;
        $display("FAIL watchdog: run still active after 90000 cycles, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "timeout");
    end

    initial begin : stim
        // baud psel byte pbit stop chg | data perr ferr
        vec[0] = '{2'd0, 1'b0, 8'h4D, 1'b0, 1'b1, 1'b0, 8'h4D, 1'b0, 1'b0};
        // 0xB3 has five ones, so odd parity wants 0; sending 1 forces a parity error
        vec[1] = '{2'd0, 1'b1, 8'hB3, 1'b1, 1'b1, 1'b0, 8'hB3, 1'b1, 1'b0};
        vec[2] = '{2'd0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
        vec[3] = '{2'd1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        vec[4] = '{2'd2, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0};
        vec[5] = '{2'd3, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};
        vec[6] = '{2'd2, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0};
        vec[7] = '{2'd1, 1'b1, 8'hC5, 1'b1, 1'b0, 1'b0, 8'hC5, 1'b0, 1'b1};
        // Config flipped after the start bit must be ignored
        vec[8] = '{2'd0, 1'b0, 8'h6E, 1'b1, 1'b1, 1'b1, 8'h6E, 1'b0, 1'b0};
        vec[9] = '{2'd3, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b1};

        rst = 1'b1;
        bus.rx = 1'b1;
        bus.baud_select = 2'd0;
        bus.parity_sel = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data",       32'(bus.data),       32'h0);
        check("rst_data_valid", 32'(bus.data_valid), 32'h0);
        check("rst_parity_err", 32'(bus.parity_err), 32'h0);
        check("rst_frame_err",  32'(bus.frame_err),  32'h0);
        check("rst_busy",       32'(bus.busy),       32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            bus.baud_select = vec[i].baud;
            bus.parity_sel  = vec[i].psel;
            len = bit_len(vec[i].baud);
            repeat (2) @(negedge clk);
            push_exp(vec[i].edata, vec[i].eperr, vec[i].eferr);
            send_frame(vec[i].b, vec[i].pbit, vec[i].stop, len, vec[i].chg);
            @(negedge clk);
            bus.rx = 1'b1;
            wait_drain("vec_drain", 4 * len);
            repeat (2 * len) @(negedge clk);
        end

        // Break: stop bit low, line held low for 20 bit times
        bus.baud_select = 2'd0;
        bus.parity_sel  = 1'b0;
        len = bit_len(2'd0);
        push_exp(8'h96, 1'b0, 1'b1);
        send_frame(8'h96, 1'b0, 1'b0, len, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            repeat (len) @(negedge clk);
            if (i == 5 || i == 19) begin
                check("break_busy",      32'(bus.busy),      32'h1);
                check("break_frame_err", 32'(bus.frame_err), 32'h1);
            end
        end
        bus.rx = 1'b1;
        repeat (8) @(negedge clk);
        check("break_release_busy", 32'(bus.busy), 32'h0);
        wait_drain("break_drain", len);
        push_exp(8'h55, 1'b0, 1'b0);
        send_frame(8'h55, 1'b0, 1'b1, len, 1'b0);
        @(negedge clk);
        bus.rx = 1'b1;
        wait_drain("after_break_drain", 4 * len);
        repeat (2 * len) @(negedge clk);

        // Start glitch of 3 ticks
        @(negedge clk);
        bus.rx = 1'b0;
        repeat (3 * (len / 16)) @(negedge clk);
        bus.rx = 1'b1;
        repeat (4) @(negedge clk);
        check("glitch_busy_seen", 32'(bus.busy), 32'h1);
        repeat (len - 3 * (len / 16) - 4) @(negedge clk);
        check("glitch_busy_clear", 32'(bus.busy), 32'h0);
        repeat (len) @(negedge clk);

        // Reset pulse in the middle of data bit 4
        f = {1'b1, 1'b0, 8'h0F, 1'b0};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus.rx = f[k];
            if (k < 5) repeat (len - 1) @(negedge clk);
        end
        repeat (len / 2) @(negedge clk);
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("abort_data",       32'(bus.data),       32'h0);
        check("abort_data_valid", 32'(bus.data_valid), 32'h0);
        check("abort_parity_err", 32'(bus.parity_err), 32'h0);
        check("abort_frame_err",  32'(bus.frame_err),  32'h0);
        check("abort_busy",       32'(bus.busy),       32'h0);
        @(negedge clk);
        bus.rx = 1'b1;
        repeat (22 * len) @(negedge clk);
        check("abort_stays_idle", 32'(bus.busy), 32'h0);
        push_exp(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b1, len, 1'b0);
        @(negedge clk);
        bus.rx = 1'b1;
        wait_drain("after_abort_drain", 4 * len);
        repeat (2 * len) @(negedge clk);

        // Back-to-back at 57600 with no idle gap
        bus.baud_select = 2'd3;
        bus.parity_sel  = 1'b0;
        len = bit_len(2'd3);
        repeat (2) @(negedge clk);
        valid_cyc.delete();
        push_exp(8'h00, 1'b0, 1'b0);
        push_exp(8'hFF, 1'b0, 1'b0);
        send_frame(8'h00, 1'b0, 1'b1, len, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b1, len, 1'b0);
        @(negedge clk);
        bus.rx = 1'b1;
        wait_drain("b2b_drain", 4 * len);
        check("b2b_count", 32'(valid_cyc.size()), 32'd2);
        if (valid_cyc.size() == 2)
            check("b2b_gap", 32'(valid_cyc[1] - valid_cyc[0]), 32'(11 * len));
        repeat (2 * len) @(negedge clk);

`ifdef RX_MAJORITY_VOTE_EN
        // One-clk inversion of data bit 2, timed to reach the synchronizer output at tick 7
        bus.baud_select = 2'd0;
        len = bit_len(2'd0);
        repeat (2) @(negedge clk);
        f = {1'b1, 1'b0, 8'h4B, 1'b0};
        push_exp(8'h4B, 1'b0, 1'b0);
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            bus.rx = f[k];
            for (int j = 1; j < len; j++) begin
                @(negedge clk);
                if (k == 3 && j == 8 * (len / 16))     bus.rx = ~f[k];
                if (k == 3 && j == 8 * (len / 16) + 1) bus.rx = f[k];
            end
        end
        @(negedge clk);
        bus.rx = 1'b1;
        wait_drain("vote_drain", 4 * len);
`endif

        wait_drain("final_drain", 100);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
